par_addsub_pipe: RTL and testbench
==================================

Name: par_addsub_pipe

Overview:
- Parametrised, pipelined successor to the team's 8-bit ripple adder/subtractor.
- Operand width and carry-segment size are generic. The carry chain is broken into registered segments so wide adds close timing.
- Adds absolute-difference and saturating-add modes for the Sobel gradient datapath, where the result is |Gx|+|Gy| clamped to pixel range.
- Uses a valid/ready handshake on both sides, so it sits between the convolution stage and the pixel writer.

Parameters:
- WIDTH, 8: operand/result width in bits. Must be a multiple of SEG.
- SEG, 4: bits resolved per pipeline stage. NSEG = WIDTH/SEG stages of carry propagation.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- a  in  WIDTH  operand A (unsigned)
- b  in  WIDTH  operand B (unsigned)
- mode  in  2  operation select: 00 add, 01 sub (a-b), 10 absdiff |a-b|, 11 saturating add
- in_valid  in  1  a/b/mode are valid
- in_ready  out  1  block accepts input this cycle
- sum  out  WIDTH  result
- cout  out  1  add: carry out; sub/absdiff: 1 when a>=b (no borrow); satadd: raw carry
- sat  out  1  satadd result was clamped
- out_valid  out  1  sum/cout/sat are valid
- out_ready  in  1  downstream accepts result

Behaviour:
- Reset (rst=1 at a clock edge):
  - All stage valid bits cleared.
  - sum=0, cout=0, sat=0, out_valid=0.
  - in_ready=1 in the cycle after reset.
  - Reset mid-operation discards every in-flight item; no partial result is ever emitted.
- Transfer rules:
  - An input transfer occurs when in_valid && in_ready.
  - An output transfer occurs when out_valid && out_ready.
- Stall: in_ready = !(out_valid && !out_ready). This is a global stall: when the output is blocked, every stage register holds its contents.
- Arithmetic:
  - Sub and absdiff use cin=1 with b inverted (two's complement). Add and satadd use cin=0.
  - Stage k (k=0..NSEG-1) computes bits [k*SEG +: SEG] with the carry registered from stage k-1.
  - Unconsumed high-order operand bits and the mode are carried forward in skew registers.
- Post stage (one extra register):
  - absdiff: if the final carry is 0 (a<b), sum = two's complement of the raw difference, else the raw difference.
  - satadd: if the final carry is 1, sum = all ones and sat=1, else the raw sum and sat=0.
  - add/sub: raw result; sat=0.
- Latency: exactly NSEG+1 cycles from input transfer to out_valid with no stall; each stall cycle adds one.
- Throughput: one result per cycle when out_ready is held high.
- Ordering is strictly FIFO. Every accepted input produces exactly one output.
- Bubbles (in_valid=0) propagate as cleared valid bits and do not stall.
- Simultaneous input and output transfer in the same cycle is legal and is the normal streaming case.
- Wrap-around: add and sub wrap modulo 2^WIDTH; cout carries the overflow/borrow information.
- Edge operand values:
  - absdiff with a==b gives 0 with cout=1.
  - absdiff 0 - (2^WIDTH-1) gives 2^WIDTH-1.
- out_valid, sum, cout and sat remain stable while out_valid && !out_ready.
- A mode change on consecutive inputs is legal; mode travels with its data.

Test Plan (WIDTH=8, SEG=4, latency 3):
- Reset then single add a=0x7F, b=0x01 -> after 3 cycles out_valid=1, sum=0x80, cout=0, sat=0; nothing before cycle 3.
- Sub a=0x05, b=0x09 -> sum=0xFC, cout=0. Absdiff same operands -> sum=0x04, cout=0. Absdiff a=b=0xAA -> sum=0x00, cout=1.
- Satadd a=0xC8, b=0x64 -> sum=0xFF, sat=1, cout=1. Satadd a=0x10, b=0x20 -> sum=0x30, sat=0.
- Back-to-back stream of 16 random mixed-mode inputs with out_ready=1 -> 16 results in order, one per cycle from cycle 3, matching the reference model.
- Hold out_ready=0 for 5 cycles mid-stream -> in_ready=0 throughout, output held stable, no loss or duplication, stream resumes in order.
- Assert rst for one cycle with 3 items in flight -> out_valid=0 next cycle, none of the flushed items ever appear; a new input gives its result 3 cycles later.

Source files
------------

// File: rtl/par_addsub_pipe.sv
// Pipelined add/sub/absdiff/satadd with segmented carry chain.
// Valid/ready on both sides; a blocked output stalls every stage.
module par_addsub_pipe #(
  parameter int WIDTH = 8,
  parameter int SEG   = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [1:0]       mode,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             sat,
  output logic             out_valid,
  input  logic             out_ready
);

  localparam int NSEG = WIDTH / SEG;
  localparam int LAST = NSEG - 1;

  logic             w_en;
  logic             w_inv;
  logic [WIDTH-1:0] w_binv;

  logic             r_ov;
  logic [WIDTH-1:0] r_sum;
  logic             r_cout;
  logic             r_sat;

  assign w_en     = !(r_ov && !out_ready);
  assign in_ready = w_en;

  assign w_inv  = (mode == 2'b01) || (mode == 2'b10);
  assign w_binv = w_inv ? ~b : b;

  genvar k;
  for (k = 0; k < NSEG; k++) begin : g_seg
    localparam int RW = WIDTH - k * SEG;

    logic [RW-1:0]        w_pa;
    logic [RW-1:0]        w_pb;
    logic                 w_pc;
    logic                 w_pv;
    logic [1:0]           w_pm;
    logic [SEG:0]         w_add;
    logic [(k+1)*SEG-1:0] w_s;

    logic                 r_v;
    logic                 r_c;
    logic [1:0]           r_m;
    logic [(k+1)*SEG-1:0] r_s;

    if (k == 0) begin : g_src
      assign w_pa = a;
      assign w_pb = w_binv;
      assign w_pc = w_inv;
      assign w_pv = in_valid;
      assign w_pm = mode;
      assign w_s  = w_add[SEG-1:0];
    end else begin : g_src
      assign w_pa = g_seg[k-1].g_skew.r_a;
      assign w_pb = g_seg[k-1].g_skew.r_b;
      assign w_pc = g_seg[k-1].r_c;
      assign w_pv = g_seg[k-1].r_v;
      assign w_pm = g_seg[k-1].r_m;
      assign w_s  = {w_add[SEG-1:0], g_seg[k-1].r_s};
    end

    assign w_add = {1'b0, w_pa[SEG-1:0]}
                 + {1'b0, w_pb[SEG-1:0]}
                 + {{SEG{1'b0}}, w_pc};

    // Resolve this segment and register its carry and partial sum.
    always_ff @(posedge clk) begin
      if (rst) begin
        r_v <= 1'b0;
      end else if (w_en) begin
        r_v <= w_pv;
        r_c <= w_add[SEG];
        r_m <= w_pm;
        r_s <= w_s;
      end
    end

    if (k < NSEG - 1) begin : g_skew
      logic [RW-SEG-1:0] r_a;
      logic [RW-SEG-1:0] r_b;

      // Carry the still-unconsumed operand bits forward.
      always_ff @(posedge clk) begin
        if (w_en) begin
          r_a <= w_pa[RW-1:SEG];
          r_b <= w_pb[RW-1:SEG];
        end
      end
    end
  end

  logic [WIDTH-1:0] w_raw;
  logic [WIDTH-1:0] w_res;
  logic             w_fc;
  logic             w_fv;
  logic             w_sat;
  logic [1:0]       w_fm;

  assign w_raw = g_seg[LAST].r_s;
  assign w_fc  = g_seg[LAST].r_c;
  assign w_fv  = g_seg[LAST].r_v;
  assign w_fm  = g_seg[LAST].r_m;

  // Mode-dependent fix-up: negate absdiff on borrow, clamp satadd.
  always_comb begin
    w_res = w_raw;
    w_sat = 1'b0;
    case (w_fm)
      2'b10: begin
        if (!w_fc) w_res = ~w_raw + 1'b1;
      end
      2'b11: begin
        if (w_fc) begin
          w_res = '1;
          w_sat = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Output register, held while downstream is not ready.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ov   <= 1'b0;
      r_sum  <= '0;
      r_cout <= 1'b0;
      r_sat  <= 1'b0;
    end else if (w_en) begin
      r_ov   <= w_fv;
      r_sum  <= w_res;
      r_cout <= w_fc;
      r_sat  <= w_sat;
    end
  end

  assign out_valid = r_ov;
  assign sum       = r_sum;
  assign cout      = r_cout;
  assign sat       = r_sat;

endmodule

// File: tb/tb_par_addsub_pipe.sv
// Self-checking bench for par_addsub_pipe (WIDTH=8, SEG=4).
// Directed vectors plus a scoreboard for streamed traffic.
module tb_par_addsub_pipe;

  logic       clk;
  logic       rst;
  logic [7:0] a;
  logic [7:0] b;
  logic [1:0] mode;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] sum;
  logic       cout;
  logic       sat;
  logic       out_valid;
  logic       out_ready;

  int n_chk = 0;
  int n_err = 0;
  int n_pop = 0;

  logic [9:0] q[$];

  logic [17:0] vec [16] = '{
    {2'd0, 8'h12, 8'h34}, {2'd1, 8'h50, 8'h20},
    {2'd2, 8'h03, 8'hF0}, {2'd3, 8'hF0, 8'h20},
    {2'd0, 8'hFF, 8'hFF}, {2'd1, 8'h00, 8'h01},
    {2'd2, 8'h80, 8'h7F}, {2'd3, 8'h40, 8'h3F},
    {2'd3, 8'h80, 8'h80}, {2'd2, 8'h00, 8'hFF},
    {2'd1, 8'hAB, 8'hAB}, {2'd0, 8'h0F, 8'h01},
    {2'd2, 8'h5A, 8'h5A}, {2'd3, 8'hFF, 8'h00},
    {2'd1, 8'h10, 8'hF0}, {2'd0, 8'h88, 8'h78}
  };

  par_addsub_pipe #(.WIDTH(8), .SEG(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .a         (a),
    .b         (b),
    .mode      (mode),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .sum       (sum),
    .cout      (cout),
    .sat       (sat),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [9:0] model(input logic [7:0] x,
                                       input logic [7:0] y,
                                       input logic [1:0] m);
    logic [8:0] s;
    logic [7:0] r;
    logic       c;
    logic       st;
    st = 1'b0;
    s  = '0;
    case (m)
      2'd0: begin
        s = x + y;
        r = s[7:0];
        c = s[8];
      end
      2'd1: begin
        r = x - y;
        c = (x >= y);
      end
      2'd2: begin
        c = (x >= y);
        r = c ? (x - y) : (y - x);
      end
      default: begin
        s  = x + y;
        c  = s[8];
        st = s[8];
        r  = st ? 8'hFF : s[7:0];
      end
    endcase
    return {st, c, r};
  endfunction

  // Scoreboard: record accepted inputs, compare delivered outputs.
  logic       p_stall = 1'b0;
  logic [9:0] p_out;
  always @(negedge clk) begin
    logic [9:0] e;
    if (rst) begin
      q.delete();
      p_stall = 1'b0;
    end else begin
      if (p_stall) begin
        chk("hold_valid", out_valid, 1);
        chk("hold_data", {sat, cout, sum}, p_out);
      end
      if (in_valid && in_ready) q.push_back(model(a, b, mode));
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          chk("unexpected_out", out_valid, 0);
        end else begin
          e = q.pop_front();
          n_pop++;
          chk("sb_sum", sum, e[7:0]);
          chk("sb_cout", cout, e[8]);
          chk("sb_sat", sat, e[9]);
        end
      end
      p_stall = out_valid && !out_ready;
      p_out   = {sat, cout, sum};
    end
  end

  task automatic put(input logic [7:0] ta,
                     input logic [7:0] tb,
                     input logic [1:0] tm);
    int n;
    a        = ta;
    b        = tb;
    mode     = tm;
    in_valid = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!in_ready && n < 50);
    if (!in_ready) chk("accept_timeout", in_ready, 1);
    @(posedge clk);
    #1;
  endtask

  task automatic dir(input string tag,
                     input logic [7:0] ta,
                     input logic [7:0] tb,
                     input logic [1:0] tm,
                     input logic [7:0] es,
                     input logic       ec,
                     input logic       esat);
    @(posedge clk);
    #1;
    put(ta, tb, tm);
    in_valid = 1'b0;
    @(negedge clk);
    chk({tag, "_ov_c1"}, out_valid, 0);
    @(negedge clk);
    chk({tag, "_ov_c2"}, out_valid, 0);
    @(negedge clk);
    chk({tag, "_ov_c3"}, out_valid, 1);
    chk({tag, "_sum"}, sum, es);
    chk({tag, "_cout"}, cout, ec);
    chk({tag, "_sat"}, sat, esat);
  endtask

  initial begin
    int base;
    rst       = 1'b1;
    in_valid  = 1'b0;
    a         = '0;
    b         = '0;
    mode      = '0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ov", out_valid, 0);
    chk("rst_sum", sum, 0);
    chk("rst_cout", cout, 0);
    chk("rst_sat", sat, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", in_ready, 1);

    dir("add7f", 8'h7F, 8'h01, 2'd0, 8'h80, 1'b0, 1'b0);
    dir("sub",   8'h05, 8'h09, 2'd1, 8'hFC, 1'b0, 1'b0);
    dir("absd",  8'h05, 8'h09, 2'd2, 8'h04, 1'b0, 1'b0);
    dir("abseq", 8'hAA, 8'hAA, 2'd2, 8'h00, 1'b1, 1'b0);
    dir("satc",  8'hC8, 8'h64, 2'd3, 8'hFF, 1'b1, 1'b1);
    dir("satn",  8'h10, 8'h20, 2'd3, 8'h30, 1'b0, 1'b0);
    dir("absmx", 8'h00, 8'hFF, 2'd2, 8'hFF, 1'b0, 1'b0);
    dir("wrap",  8'hFF, 8'h01, 2'd0, 8'h00, 1'b1, 1'b0);

    // Back-to-back stream, one result per cycle.
    repeat (2) @(posedge clk);
    #1;
    base = n_pop;
    for (int i = 0; i < 16; i++)
      put(vec[i][15:8], vec[i][7:0], vec[i][17:16]);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("stream_c17", n_pop - base, 15);
    @(negedge clk);
    #1;
    chk("stream_c18", n_pop - base, 16);

    // Stall the output for five cycles mid-stream.
    repeat (2) @(posedge clk);
    #1;
    base = n_pop;
    fork
      begin
        for (int i = 0; i < 12; i++)
          put(vec[15-i][15:8], vec[15-i][7:0], vec[15-i][17:16]);
        in_valid = 1'b0;
      end
      begin
        repeat (5) @(posedge clk);
        #1;
        out_ready = 1'b0;
        repeat (5) begin
          @(negedge clk);
          chk("stall_in_ready", in_ready, 0);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    repeat (6) @(negedge clk);
    #1;
    chk("stall_count", n_pop - base, 12);
    chk("stall_drain", q.size(), 0);

    // Flush three in-flight items with a one-cycle reset.
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    put(8'h11, 8'h22, 2'd0);
    put(8'h33, 8'h44, 2'd1);
    put(8'h55, 8'h66, 2'd3);
    in_valid = 1'b0;
    rst      = 1'b1;
    @(posedge clk);
    #1;
    rst       = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    chk("flush_ov", out_valid, 0);
    chk("flush_in_ready", in_ready, 1);
    dir("postrst", 8'h20, 8'h30, 2'd1, 8'hF0, 1'b0, 1'b0);
    repeat (6) @(negedge clk);
    #1;
    chk("final_drain", q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d errors", n_err);
    $fatal(1, "watchdog");
  end

endmodule
